oled_msg_scheduler: RTL

- Decides which message screen the OLED shows, and when the OLED controller redraws it.
- Requesters are the vending controller's event strobes: error, dispensed, insufficient funds, coin accepted.
- Pending requests are latched, then granted by fixed priority with a minimum on-screen hold time. Error preempts everything.
- Drives the message-select index into the page ROM mux, plus a redraw-enable strobe aligned to the 10 Hz tick (replaces the free-running EN).

---
 rtl/vm_pkg.sv | 20 ++
 rtl/oled_msg_scheduler_if.sv | 16 +
 rtl/prio_enc_lsb.sv | 23 ++
 rtl/oled_msg_scheduler.sv | 115 +++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared constants for the OLED message scheduler: screen indices,
// FSM encoding and the default on-screen hold time.
package vm_pkg;

  localparam int MSG_ERROR   = 0;
  localparam int MSG_VEND    = 1;
  localparam int MSG_NOFUNDS = 2;
  localparam int MSG_COIN    = 3;
  localparam int MSG_BANNER  = 4;

  localparam int DEFAULT_HOLD_TICKS = 20;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ARB       = 2'd1;
  localparam logic [1:0] ST_WAIT_TICK = 2'd2;
  localparam logic [1:0] ST_SHOW      = 2'd3;

endpackage

// File: rtl/oled_msg_scheduler_if.sv
// Request/display bundle between the vending controller side and the
// message scheduler.
interface oled_msg_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 3
);
  logic               tick;
  logic [NUM_REQ-1:0] req;
  logic [SEL_W-1:0]   msg_sel;
  logic               oled_en;
  logic [NUM_REQ-1:0] grant;
  logic               busy;

  modport master (output tick, req, input msg_sel, oled_en, grant, busy);
  modport slave  (input tick, req, output msg_sel, oled_en, grant, busy);
endinterface

// File: rtl/prio_enc_lsb.sv
// Lowest-set-bit priority encoder: index, one-hot and any-set flag.
module prio_enc_lsb #(
  parameter int N     = 4,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot,
  output logic             any
);

  assign any    = |vec;
  assign onehot = vec & (~vec + N'(1));

  // Scanning downward lets the lowest set bit write last.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/oled_msg_scheduler.sv
// Latches display requests, grants them by fixed priority with a minimum
// hold time, and paces OLED redraws to the 10 Hz tick.
//
// state     | meaning
// IDLE      | banner shown, waiting for a pending request
// ARB       | one cycle: pick lowest pending index, grant it
// WAIT_TICK | new selection made, redraw on the next tick
// SHOW      | message on screen, counting down the hold time
module oled_msg_scheduler
  import vm_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int HOLD_TICKS = DEFAULT_HOLD_TICKS,
  parameter int SEL_W      = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  oled_msg_scheduler_if.slave  bus
);

  localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [SEL_W-1:0] BANNER = SEL_W'(NUM_REQ);

  state_t             state, state_nx;
  logic [NUM_REQ-1:0] pending, pend_nx, clr, grant_nx;
  logic [NUM_REQ-1:0] win_oh;
  logic [SEL_W-1:0]   win_idx, sel_nx;
  logic               win_any, en_nx, preempt;
  logic [HOLD_W-1:0]  hold_cnt, hold_nx;

  prio_enc_lsb #(.N(NUM_REQ), .IDX_W(SEL_W)) u_enc (
    .vec    (pending),
    .idx    (win_idx),
    .onehot (win_oh),
    .any    (win_any)
  );

  // Only the error source cuts a hold short, and never while it is itself shown.
  assign preempt = pending[0] && (bus.msg_sel != SEL_W'(MSG_ERROR)) &&
                   ((state == ST_SHOW) || (state == ST_WAIT_TICK));

  always_comb begin
    state_nx = state;
    sel_nx   = bus.msg_sel;
    hold_nx  = hold_cnt;
    clr      = '0;
    grant_nx = '0;
    en_nx    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|pending) state_nx = ST_ARB;
      end
      ST_ARB: begin
        state_nx = ST_WAIT_TICK;
        if (win_any) begin
          sel_nx   = win_idx;
          grant_nx = win_oh;
          clr      = win_oh;
        end else begin
          sel_nx = BANNER;
        end
      end
      ST_WAIT_TICK: begin
        if (preempt) begin
          state_nx = ST_ARB;
        end else if (bus.tick) begin
          en_nx = 1'b1;
          if (bus.msg_sel == BANNER) begin
            state_nx = ST_IDLE;
          end else begin
            hold_nx  = HOLD_W'(HOLD_TICKS - 1);
            state_nx = ST_SHOW;
          end
        end
      end
      ST_SHOW: begin
        if (preempt) begin
          state_nx = ST_ARB;
        end else if (bus.tick) begin
          if (hold_cnt != '0) begin
            hold_nx = hold_cnt - HOLD_W'(1);
          end else if (|pending) begin
            state_nx = ST_ARB;
          end else begin
            sel_nx   = BANNER;
            state_nx = ST_WAIT_TICK;
          end
        end
      end
      default: state_nx = ST_WAIT_TICK;
    endcase
    pend_nx = (pending & ~clr) | bus.req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_WAIT_TICK;
      bus.msg_sel <= BANNER;
      pending     <= '0;
      hold_cnt    <= '0;
      bus.oled_en <= 1'b0;
      bus.grant   <= '0;
      bus.busy    <= 1'b0;
    end else begin
      state       <= state_nx;
      bus.msg_sel <= sel_nx;
      pending     <= pend_nx;
      hold_cnt    <= hold_nx;
      bus.oled_en <= en_nx;
      bus.grant   <= grant_nx;
      bus.busy    <= (sel_nx != BANNER) | (|pend_nx);
    end
  end

endmodule
